// File: rtl/ram_1p_bist.sv
// ram_1p_bist: built-in self test initiator for a ram_1p single-port 32-bit RAM.
// Writes a seed-derived pattern to every word, reads it back and compares,
// reporting pass/fail, a saturating error count and the first failing address.
// Optional feature macro: RAM_BIST_INV_PASS_EN adds an inverted write/read pass.
module ram_1p_bist #(
    parameter int unsigned Depth    = 128,
    parameter logic [31:0] BaseAddr = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] seed_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [15:0] err_cnt_o,
    output logic [31:0] err_addr_o,
    output logic        req_o,
    output logic        we_o,
    output logic [3:0]  be_o,
    output logic [31:0] addr_o,
    output logic [31:0] wdata_o,
    input  logic        rvalid_i,
    input  logic [31:0] rdata_i
);

    localparam int unsigned Aw = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [Aw-1:0] IdxLast = Aw'(Depth - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_PAT = 3'd1,
        RD_PAT = 3'd2,
`ifdef RAM_BIST_INV_PASS_EN
        WR_INV = 3'd3,
        RD_INV = 3'd4,
`endif
        DRAIN  = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [Aw-1:0] idx_q, idx_d;
    logic [31:0]   seed_q;
    logic [15:0]   idx16;
    logic [31:0]   pat;
    logic [31:0]   addr_word;
    logic          rd_req;
    logic          inv_sel;
    logic          rd_pend_q;
    logic [31:0]   exp_q;
    logic [31:0]   exp_addr_q;
    logic          mismatch;
    logic [15:0]   err_cnt_q, err_cnt_d;
    logic [31:0]   err_addr_q, err_addr_d;
    logic          pass_q;
    logic          done_q;

    assign idx16     = 16'(idx_q);
    assign pat       = seed_q ^ {idx16, ~idx16};
    assign addr_word = BaseAddr + (32'(idx_q) << 2);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, index advance and RAM request decode
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        req_o   = 1'b0;
        we_o    = 1'b0;
        be_o    = '0;
        addr_o  = '0;
        wdata_o = '0;
        rd_req  = 1'b0;
        inv_sel = 1'b0;
        busy_o  = 1'b1;
        case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    state_d = WR_PAT;
                    idx_d   = '0;
                end
            end
            WR_PAT: begin
                req_o   = 1'b1;
                we_o    = 1'b1;
                wdata_o = pat;
                idx_d   = idx_q + Aw'(1);
                if (idx_q == IdxLast) state_d = RD_PAT;
            end
            RD_PAT: begin
                req_o  = 1'b1;
                rd_req = 1'b1;
                idx_d  = idx_q + Aw'(1);
`ifdef RAM_BIST_INV_PASS_EN
                if (idx_q == IdxLast) state_d = WR_INV;
`else
                if (idx_q == IdxLast) state_d = DRAIN;
`endif
            end
`ifdef RAM_BIST_INV_PASS_EN
            WR_INV: begin
                req_o   = 1'b1;
                we_o    = 1'b1;
                wdata_o = ~pat;
                idx_d   = idx_q + Aw'(1);
                if (idx_q == IdxLast) state_d = RD_INV;
            end
            RD_INV: begin
                req_o   = 1'b1;
                rd_req  = 1'b1;
                inv_sel = 1'b1;
                idx_d   = idx_q + Aw'(1);
                if (idx_q == IdxLast) state_d = DRAIN;
            end
`endif
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                busy_o  = 1'b0;
                state_d = IDLE;
            end
        endcase
        if (req_o) begin
            be_o   = 4'hF;
            addr_o = addr_word;
        end
    end

    // Read-data compare: saturating error count, first failing address latched once
    always_comb begin
        mismatch   = rd_pend_q && (!rvalid_i || (rdata_i != exp_q));
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
        if (mismatch) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 16'd1;
            if (err_cnt_q == '0) err_addr_d = exp_addr_q;
        end
    end

    // Datapath registers: index, seed, compare pipeline and results
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q      <= '0;
            seed_q     <= '0;
            rd_pend_q  <= 1'b0;
            exp_q      <= '0;
            exp_addr_q <= '0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
            pass_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            rd_pend_q  <= rd_req;
            exp_q      <= rd_req ? (inv_sel ? ~pat : pat) : '0;
            exp_addr_q <= addr_word;
            done_q     <= (state_q == DRAIN);
            if (state_q == IDLE && start_i) begin
                seed_q     <= seed_i;
                err_cnt_q  <= '0;
                err_addr_q <= '0;
                pass_q     <= 1'b0;
            end else begin
                err_cnt_q  <= err_cnt_d;
                err_addr_q <= err_addr_d;
                // the last read is compared during DRAIN, so pass uses the updated count
                if (state_q == DRAIN) pass_q <= (err_cnt_d == '0);
            end
        end
    end

    assign done_o     = done_q;
    assign pass_o     = pass_q;
    assign err_cnt_o  = err_cnt_q;
    assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_ram_1p_bist.sv
// tb_ram_1p_bist: bench for ram_1p_bist with a small (Depth 4) and a large
// (Depth 128, base 0x1000) instance, each behind a simple one-cycle RAM.
module tb_ram_1p_bist;

    localparam int D = 4;
`ifdef RAM_BIST_INV_PASS_EN
    localparam int NPH = 4;
`else
    localparam int NPH = 2;
`endif
    localparam int N  = NPH * D;
    localparam int DB = 128;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] seed_i = '0;
    logic        busy_o, done_o, pass_o, req_o, we_o, rvalid_i;
    logic [15:0] err_cnt_o;
    logic [31:0] err_addr_o, addr_o, wdata_o, rdata_i;
    logic [3:0]  be_o;

    logic        start_b = 1'b0;
    logic [31:0] seed_b = '0;
    logic        busy_b, done_b, pass_b, req_b, we_b, rvalid_b;
    logic [15:0] err_cnt_b;
    logic [31:0] err_addr_b, addr_b, wdata_b, rdata_b;
    logic [3:0]  be_b;

    always #5 clk = ~clk;

    ram_1p_bist #(.Depth(D), .BaseAddr(32'h0)) u_dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .seed_i(seed_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
        .err_cnt_o(err_cnt_o), .err_addr_o(err_addr_o),
        .req_o(req_o), .we_o(we_o), .be_o(be_o), .addr_o(addr_o),
        .wdata_o(wdata_o), .rvalid_i(rvalid_i), .rdata_i(rdata_i)
    );

    ram_1p_bist #(.Depth(DB), .BaseAddr(32'h1000)) u_big (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_b), .seed_i(seed_b),
        .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b),
        .err_cnt_o(err_cnt_b), .err_addr_o(err_addr_b),
        .req_o(req_b), .we_o(we_b), .be_o(be_b), .addr_o(addr_b),
        .wdata_o(wdata_b), .rvalid_i(rvalid_b), .rdata_i(rdata_b)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pat_f(input logic [31:0] s, input int i);
        logic [31:0] iv;
        iv = 32'(i);
        return s ^ (((iv & 32'hFFFF) << 16) | (~iv & 32'hFFFF));
    endfunction

    // RAM models with fault injection on the small instance
    logic [31:0] mem [D];
    logic [31:0] mem_b [DB];
    logic        flip_w2 = 1'b0;
    logic        stuck31_w1 = 1'b0;
    logic [31:0] rd_tmp;

    always @(posedge clk) begin
        rvalid_i <= req_o;
        rdata_i  <= '0;
        if (req_o) begin
            if (we_o) begin
                mem[addr_o[3:2]] <= wdata_o;
            end else begin
                rd_tmp = mem[addr_o[3:2]];
                if (flip_w2 && addr_o[3:2] == 2'd2) rd_tmp[0] = ~rd_tmp[0];
                if (stuck31_w1 && addr_o[3:2] == 2'd1) rd_tmp[31] = 1'b1;
                rdata_i <= rd_tmp;
            end
        end
    end

    always @(posedge clk) begin
        rvalid_b <= req_b;
        rdata_b  <= '0;
        if (req_b) begin
            if (we_b) mem_b[addr_b[8:2]] <= wdata_b;
            else      rdata_b <= mem_b[addr_b[8:2]];
        end
    end

    // Reference model: m_k is the cycle number within the current test (0 = idle)
    int          m_k = 0;
    logic [31:0] m_seed = '0;
    logic        m_done = 1'b0;
    logic        m_pass = 1'b0;
    int          m_err = 0;
    logic [31:0] m_eaddr = '0;
    logic        chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst_i) begin
            m_k    <= 0;
            m_done <= 1'b0;
            m_pass <= 1'b0;
        end else begin
            m_done <= (m_k == N + 1);
            if (m_k == N + 1) begin
                m_k    <= 0;
                m_pass <= (m_err == 0);
            end else if (m_k > 0) begin
                m_k <= m_k + 1;
            end else if (start_i) begin
                m_k    <= 1;
                m_seed <= seed_i;
                m_pass <= 1'b0;
            end
        end
    end

    // Per-cycle compare of the small instance against the model
    always @(negedge clk) begin
        if (chk_en) begin
            int p, i, pp, ip;
            logic e_req, e_we;
            logic [31:0] e_wd, e_rd;
            e_req = (m_k >= 1 && m_k <= N);
            p = (m_k - 1) / D;
            i = (m_k - 1) % D;
            e_we = (p % 2 == 0);
            e_wd = pat_f(m_seed, i);
            if (p >= 2) e_wd = ~e_wd;
            chk("req_o", 32'(req_o), 32'(e_req));
            if (e_req) begin
                chk("we_o", 32'(we_o), 32'(e_we));
                chk("be_o", 32'(be_o), 32'hF);
                chk("addr_o", addr_o, 32'(4 * i));
                chk("wdata_o", wdata_o, e_we ? e_wd : 32'h0);
            end
            chk("busy_o", 32'(busy_o), 32'(m_k >= 1 && m_k <= N + 1));
            chk("done_o", 32'(done_o), 32'(m_done));
            chk("pass_o", 32'(pass_o), 32'(m_pass));
            if (m_done) begin
                chk("err_cnt_o@done", 32'(err_cnt_o), 32'(m_err));
                chk("err_addr_o@done", err_addr_o, m_eaddr);
            end
            if (m_k == 1) begin
                m_err   = 0;
                m_eaddr = '0;
            end
            // scoreboard: the read issued last cycle is returned this cycle
            if (m_k >= 2 && m_k <= N + 1) begin
                pp = (m_k - 2) / D;
                ip = (m_k - 2) % D;
                if (pp % 2 == 1) begin
                    e_rd = pat_f(m_seed, ip);
                    if (pp >= 2) e_rd = ~e_rd;
                    if (!rvalid_i || rdata_i != e_rd) begin
                        if (m_err == 0) m_eaddr = 32'(4 * ip);
                        if (m_err < 65535) m_err++;
                    end
                end
            end
        end
    end

    int          pulse_at = -1;
    int          busy_cnt;
    logic [31:0] cap_wd [D];
    logic [31:0] cap_ad [D];

    task automatic wait_done(output int cyc);
        int c;
        c = 0;
        busy_cnt = 0;
        do begin
            @(negedge clk);
            c++;
            start_i = (c == pulse_at);
            if (busy_o) busy_cnt++;
            if (c <= D && req_o && we_o) begin
                cap_wd[c-1] = wdata_o;
                cap_ad[c-1] = addr_o;
            end
        end while (!done_o && c < 500);
        if (!done_o) chk("done_timeout", 32'(c), 32'(N + 2));
        cyc = c;
    endtask

    task automatic run_small(input logic [31:0] seed, output int cyc);
        seed_i  = seed;
        start_i = 1'b1;
        wait_done(cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, c, nreq, firstr, lastr;
        logic [31:0] lastaddr;
        logic [31:0] exp_wd [D];
        exp_wd[0] = 32'hA5A5FFFF; exp_wd[1] = 32'hA5A4FFFE;
        exp_wd[2] = 32'hA5A7FFFD; exp_wd[3] = 32'hA5A6FFFC;

        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        // reset state
        chk("rst req_o", 32'(req_o), 0);
        chk("rst we_o", 32'(we_o), 0);
        chk("rst be_o", 32'(be_o), 0);
        chk("rst addr_o", addr_o, 0);
        chk("rst wdata_o", wdata_o, 0);
        chk("rst busy_o", 32'(busy_o), 0);
        chk("rst done_o", 32'(done_o), 0);
        chk("rst pass_o", 32'(pass_o), 0);
        chk("rst err_cnt_o", 32'(err_cnt_o), 0);
        chk("rst err_addr_o", err_addr_o, 0);
        rst_i = 1'b0;
        @(negedge clk);

        // 1: clean run
        run_small(32'hA5A5_0000, cyc);
        for (int i = 0; i < D; i++) begin
            chk("t1 write data", cap_wd[i], exp_wd[i]);
            chk("t1 write addr", cap_ad[i], 32'(4 * i));
        end
        chk("t1 done cycle", 32'(cyc), 32'(N + 2));
`ifndef RAM_BIST_INV_PASS_EN
        chk("t1 done cycle literal", 32'(cyc), 32'd10);
`endif
        chk("t1 pass_o", 32'(pass_o), 1);
        chk("t1 err_cnt_o", 32'(err_cnt_o), 0);

        // 2: bit 0 of word 2 flipped on read
        @(negedge clk);
        flip_w2 = 1'b1;
        run_small(32'hA5A5_0000, cyc);
`ifdef RAM_BIST_INV_PASS_EN
        chk("t2 err_cnt_o", 32'(err_cnt_o), 2);
`else
        chk("t2 err_cnt_o", 32'(err_cnt_o), 1);
`endif
        chk("t2 err_addr_o", err_addr_o, 32'h8);
        chk("t2 pass_o", 32'(pass_o), 0);
        flip_w2 = 1'b0;

        // 3: bit 31 of word 1 stuck at 1, seed 0
        @(negedge clk);
        stuck31_w1 = 1'b1;
        run_small(32'h0, cyc);
        chk("t3 err_cnt_o", 32'(err_cnt_o), 1);
        chk("t3 err_addr_o", err_addr_o, 32'h4);
        chk("t3 pass_o", 32'(pass_o), 0);
`ifdef RAM_BIST_INV_PASS_EN
        chk("t3 busy cycles", 32'(busy_cnt), 17);
`else
        chk("t3 busy cycles", 32'(busy_cnt), 9);
`endif
        stuck31_w1 = 1'b0;

        // 5: reset during RD_PAT at idx 2
        @(negedge clk);
        seed_i  = 32'h1234_5678;
        start_i = 1'b1;
        c = 0;
        do begin
            @(negedge clk);
            c++;
            start_i = 1'b0;
        end while (c < D + 3);
        chk("t5 rd idx2 addr", addr_o, 32'h8);
        chk("t5 rd idx2 we", 32'(we_o), 0);
        rst_i = 1'b1;
        @(negedge clk);
        chk("t5 req_o after rst", 32'(req_o), 0);
        chk("t5 busy_o after rst", 32'(busy_o), 0);
        chk("t5 done_o after rst", 32'(done_o), 0);
        chk("t5 err_cnt_o after rst", 32'(err_cnt_o), 0);
        rst_i = 1'b0;
        nreq = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_o) nreq++;
        end
        chk("t5 no done after abort", 32'(nreq), 0);
        run_small(32'h1234_5678, cyc);
        chk("t5 restart pass_o", 32'(pass_o), 1);

        // 6: start while busy ignored, start in done cycle accepted
        @(negedge clk);
        pulse_at = 3;
        run_small(32'hDEAD_BEEF, cyc);
        pulse_at = -1;
        chk("t6 ignored start done cycle", 32'(cyc), 32'(N + 2));
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("t6 back-to-back busy_o", 32'(busy_o), 1);
        chk("t6 back-to-back done_o", 32'(done_o), 0);
        wait_done(cyc);
        chk("t6 second run done cycle", 32'(cyc), 32'(N + 1));
        chk("t6 second run pass_o", 32'(pass_o), 1);

        // 4: Depth 128, base 0x1000
        @(negedge clk);
        seed_b  = 32'h0F0F_3C3C;
        start_b = 1'b1;
        c = 0; nreq = 0; firstr = 0; lastr = 0; lastaddr = '0;
        do begin
            @(negedge clk);
            c++;
            start_b = 1'b0;
            if (req_b) begin
                if (nreq == 0) firstr = c;
                lastr = c;
                nreq++;
                lastaddr = addr_b;
            end
            if (c == DB)     chk("t4 last write addr", addr_b, 32'h11FC);
            if (c == DB + 1) begin
                chk("t4 first read req", 32'(req_b), 1);
                chk("t4 first read we", 32'(we_b), 0);
                chk("t4 first read addr", addr_b, 32'h1000);
            end
        end while (!done_b && c < 2000);
        chk("t4 done seen", 32'(done_b), 1);
        chk("t4 request count", 32'(nreq), 32'(NPH * DB));
        chk("t4 no req gap", 32'(lastr - firstr + 1), 32'(nreq));
        chk("t4 last addr_o", lastaddr, 32'h11FC);
        chk("t4 pass_o", 32'(pass_b), 1);
        chk("t4 err_cnt_o", 32'(err_cnt_b), 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
